// File: rtl/t03_timer_pkg.sv
// t03_timer_pkg: shared constants and types for the compare/alarm timer.
// Register map, CTRL/STATUS bit positions, FSM state encoding and the
// COMPARE reset value live here so the top and register file agree.
package t03_timer_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_COMPARE = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_IRQEN_BIT    = 2;

  localparam int STAT_MATCH_BIT = 0;
  localparam int STAT_OVR_BIT   = 1;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_e;

endpackage

// File: rtl/t03_timer_regs.sv
// t03_timer_regs: register file for the compare timer.
// Holds CTRL, COMPARE, PERIOD and the W1C STATUS bits, applies the periodic
// reload on a hit, and produces registered read data (pre-write values).
// Build option T03_TIMER_PERIODIC_EN: when undefined, PERIOD and CTRL[1]
// are not stored and read back as zero.
import t03_timer_pkg::*;

module t03_timer_regs (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wen_i,
  input  logic        ren_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic        hit_i,
  output logic [31:0] rdata_o,
  output logic [31:0] compare_o,
  output logic        periodic_o,
  output logic        ctrl_wr_o,
  output logic        ctrl_en_wr_o,
  output logic        match_clr_o,
  output logic        match_d_o,
  output logic        irq_en_d_o
);

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] period_q;
  logic        match_q, match_d;
  logic        ovr_q, ovr_d;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;

  logic ctrl_wr, cmp_wr, stat_wr;

  assign ctrl_wr = wen_i && (addr_i == ADDR_CTRL);
  assign cmp_wr  = wen_i && (addr_i == ADDR_COMPARE);
  assign stat_wr = wen_i && (addr_i == ADDR_STATUS);

`ifdef T03_TIMER_PERIODIC_EN
  logic per_wr;
  assign per_wr = wen_i && (addr_i == ADDR_PERIOD);

  // PERIOD register: plain write-only-by-software storage.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      period_q <= '0;
    end else if (per_wr) begin
      period_q <= wdata_i;
    end
  end
`else
  assign period_q = '0;
`endif

  // Next-state for CTRL, COMPARE and STATUS; software writes beat the reload,
  // a hit beats a same-cycle W1C of match.
  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_wr) begin
      ctrl_d = wdata_i[2:0];
    end
`ifndef T03_TIMER_PERIODIC_EN
    ctrl_d[CTRL_PERIODIC_BIT] = 1'b0;
`endif

    compare_d = compare_q;
    if (hit_i && ctrl_q[CTRL_PERIODIC_BIT]) begin
      compare_d = compare_q + period_q;
    end
    if (cmp_wr) begin
      compare_d = wdata_i;
    end

    match_d = (match_q && !(stat_wr && wdata_i[STAT_MATCH_BIT])) || hit_i;
    ovr_d   = (ovr_q && !(stat_wr && wdata_i[STAT_OVR_BIT])) || (hit_i && match_q);
  end

  // Register state update.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ctrl_q    <= '0;
      compare_q <= COMPARE_RST;
      match_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      ovr_q     <= ovr_d;
    end
  end

  // Read mux over current (pre-write) register values.
  always_comb begin
    rd_mux = '0;
    case (addr_i)
      ADDR_CTRL:    rd_mux = {29'd0, ctrl_q};
      ADDR_COMPARE: rd_mux = compare_q;
      ADDR_PERIOD:  rd_mux = period_q;
      ADDR_STATUS:  rd_mux = {30'd0, ovr_q, match_q};
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data; holds its value when no read is requested.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rdata_q <= '0;
    end else if (ren_i) begin
      rdata_q <= rd_mux;
    end
  end

  assign rdata_o      = rdata_q;
  assign compare_o    = compare_q;
  assign periodic_o   = ctrl_q[CTRL_PERIODIC_BIT];
  assign ctrl_wr_o    = ctrl_wr;
  assign ctrl_en_wr_o = wdata_i[CTRL_EN_BIT];
  assign match_clr_o  = stat_wr && wdata_i[STAT_MATCH_BIT];
  assign match_d_o    = match_d;
  assign irq_en_d_o   = ctrl_d[CTRL_IRQEN_BIT];

endmodule

// File: rtl/t03_timer_compare.sv
// t03_timer_compare: compare/alarm timer watching a free-running tick count.
// Detects tick changes, compares against COMPARE while ARMED, and drives a
// registered level interrupt. Register storage is in t03_timer_regs.
// Build option T03_TIMER_PERIODIC_EN enables periodic re-arm (see regs).
import t03_timer_pkg::*;

module t03_timer_compare (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] tick_count,
  input  logic        wen,
  input  logic        ren,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e      state_q;
  logic [31:0] prev_count_q;
  logic        irq_q;

  logic [31:0] compare;
  logic        periodic;
  logic        ctrl_wr, ctrl_en_wr, match_clr, match_d, irq_en_d;
  logic        new_tick, hit;

  // A hit needs a fresh tick so a stalled count cannot fire repeatedly.
  assign new_tick = (tick_count != prev_count_q);
  assign hit      = (state_q == ST_ARMED) && new_tick && (tick_count == compare);

  t03_timer_regs u_regs (
    .clk          (clk),
    .nrst         (nrst),
    .wen_i        (wen),
    .ren_i        (ren),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .hit_i        (hit),
    .rdata_o      (rdata),
    .compare_o    (compare),
    .periodic_o   (periodic),
    .ctrl_wr_o    (ctrl_wr),
    .ctrl_en_wr_o (ctrl_en_wr),
    .match_clr_o  (match_clr),
    .match_d_o    (match_d),
    .irq_en_d_o   (irq_en_d)
  );

  // Track the previous tick count for change detection.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_count_q <= '0;
    end else begin
      prev_count_q <= tick_count;
    end
  end

  // Arming FSM: a CTRL write decides IDLE/ARMED outright, otherwise a
  // one-shot hit parks in FIRED until match is acknowledged.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= match_d && irq_en_d;
      if (ctrl_wr) begin
        state_q <= ctrl_en_wr ? ST_ARMED : ST_IDLE;
      end else begin
        case (state_q)
          ST_ARMED: if (hit && !periodic) state_q <= ST_FIRED;
          ST_FIRED: if (match_clr) state_q <= ST_ARMED;
          default:  state_q <= state_q;
        endcase
      end
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_t03_timer_compare.sv
// Self-checking bench for t03_timer_compare with directed vectors.
module tb_t03_timer_compare;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] tick_count = '0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  t03_timer_compare dut (
    .clk        (clk),
    .nrst       (nrst),
    .tick_count (tick_count),
    .wen        (wen),
    .ren        (ren),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wen = 1'b1; addr = a; wdata = d;
    step();
    wen = 1'b0;
    $display("WR   addr=%0d data=%08h tick=%08h", a, d, tick_count);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    ren = 1'b1; addr = a;
    step();
    ren = 1'b0;
    v = rdata;
    $display("RD   addr=%0d data=%08h tick=%08h", a, v, tick_count);
  endtask

  task automatic tick_to(input logic [31:0] t);
    tick_count = t;
    step();
    $display("TICK tick=%08h irq=%0b", t, irq);
  endtask

  task automatic do_reset();
    wen = 1'b0; ren = 1'b0; tick_count = '0;
    nrst = 1'b0;
    repeat (2) step();
    nrst = 1'b1;
    step();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %0b expected 0", irq); end
    rd(2'd0, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl: got %08h expected 0", v); end
    rd(2'd1, v); n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_compare: got %08h expected FFFFFFFF", v); end
    rd(2'd2, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_period: got %08h expected 0", v); end
    rd(2'd3, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %08h expected 0", v); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    logic        exp_irq;
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h5);
    for (int t = 1; t <= 7; t++) begin
      tick_to(t);
      exp_irq = (t >= 5);
      n_cmp++;
      if (irq !== exp_irq) begin n_bad++; $display("FAIL oneshot_irq t=%0d: got %0b expected %0b", t, irq, exp_irq); end
    end
    rd(2'd3, v); n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL oneshot_status: got %08h expected 1", v); end
    wr(2'd3, 32'h1);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL oneshot_irq_clear: got %0b expected 0", irq); end
    rd(2'd1, v); n_cmp++; if (v !== 32'd5) begin n_bad++; $display("FAIL oneshot_compare: got %08h expected 5", v); end
  endtask

`ifdef T03_TIMER_PERIODIC_EN
  task automatic test_periodic();
    logic [31:0] v;
    logic [31:0] exp_st;
    do_reset();
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h7);
    rd(2'd0, v); n_cmp++; if (v !== 32'h7) begin n_bad++; $display("FAIL per_ctrl: got %08h expected 7", v); end
    for (int t = 1; t <= 7; t++) begin
      tick_to(t);
      if (t == 4) begin
        rd(2'd3, v); n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL per_first_hit: got %08h expected 1", v); end
        rd(2'd1, v); n_cmp++; if (v !== 32'd7) begin n_bad++; $display("FAIL per_reload: got %08h expected 7", v); end
      end
    end
    rd(2'd3, v); n_cmp++; if (v !== 32'h3) begin n_bad++; $display("FAIL per_overrun: got %08h expected 3", v); end
    wr(2'd3, 32'h3);
    for (int t = 8; t <= 13; t++) begin
      tick_to(t);
      exp_st = (t == 10 || t == 13) ? 32'h1 : 32'h0;
      rd(2'd3, v); n_cmp++;
      if (v !== exp_st) begin n_bad++; $display("FAIL per_status t=%0d: got %08h expected %08h", t, v, exp_st); end
      if (v[0]) wr(2'd3, 32'h1);
    end
    rd(2'd1, v); n_cmp++; if (v !== 32'd16) begin n_bad++; $display("FAIL per_compare_end: got %08h expected 16", v); end
  endtask
`else
  task automatic test_periodic();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h7);
    rd(2'd0, v); n_cmp++; if (v !== 32'h5) begin n_bad++; $display("FAIL noper_ctrl: got %08h expected 5", v); end
    rd(2'd2, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL noper_period: got %08h expected 0", v); end
    for (int t = 1; t <= 7; t++) tick_to(t);
    rd(2'd3, v); n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL noper_status: got %08h expected 1", v); end
    rd(2'd1, v); n_cmp++; if (v !== 32'd4) begin n_bad++; $display("FAIL noper_compare: got %08h expected 4", v); end
  endtask
`endif

  task automatic test_static_count();
    logic [31:0] v;
    do_reset();
    tick_to(32'd4);
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);
    tick_to(32'd5);
    rd(2'd3, v); n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL static_first: got %08h expected 1", v); end
    wr(2'd3, 32'h1);
    repeat (8) step();
    rd(2'd3, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL static_no_rehit: got %08h expected 0", v); end
  endtask

  task automatic test_races();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    tick_to(32'd1);
    tick_to(32'd2);
    // hit coincident with W1C of match
    tick_count = 32'd3; wen = 1'b1; addr = 2'd3; wdata = 32'h1;
    step();
    wen = 1'b0;
    rd(2'd3, v); n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL race_w1c: got %08h expected 1", v); end
    // read and write of CTRL in the same cycle returns the old value
    wen = 1'b1; ren = 1'b1; addr = 2'd0; wdata = 32'h3;
    step();
    wen = 1'b0; ren = 1'b0;
    n_cmp++; if (rdata !== 32'h1) begin n_bad++; $display("FAIL race_rdwr: got %08h expected 1", rdata); end
    wr(2'd2, 32'd10);
    wr(2'd3, 32'h3);
    wr(2'd1, 32'd6);
    tick_to(32'd5);
    // hit coincident with COMPARE write
    tick_count = 32'd6; wen = 1'b1; addr = 2'd1; wdata = 32'd100;
    step();
    wen = 1'b0;
    rd(2'd1, v); n_cmp++; if (v !== 32'd100) begin n_bad++; $display("FAIL race_cmp_write: got %08h expected 100", v); end
    rd(2'd3, v); n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL race_cmp_hit: got %08h expected 1", v); end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    do_reset();
    tick_to(32'hFFFF_FFFE);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h5);
    tick_to(32'hFFFF_FFFF);
    rd(2'd3, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL wrap_ffffffff: got %08h expected 0", v); end
    tick_to(32'h0);
    rd(2'd3, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL wrap_zero: got %08h expected 0", v); end
    tick_to(32'h1);
    rd(2'd3, v); n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL wrap_hit: got %08h expected 1", v); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL wrap_irq: got %0b expected 1", irq); end
    // asynchronous reset pulse mid-run
    #2 nrst = 1'b0;
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL async_rst_irq: got %0b expected 0", irq); end
    step();
    nrst = 1'b1;
    step();
    rd(2'd0, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_ctrl: got %08h expected 0", v); end
    rd(2'd1, v); n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_compare: got %08h expected FFFFFFFF", v); end
    rd(2'd2, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_period: got %08h expected 0", v); end
    rd(2'd3, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_status: got %08h expected 0", v); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_static_count();
    test_races();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
